max_pool_stream: RTL and testbench

MAX_POOL_STREAM -- requirements
Module: max_pool_stream

---
 rtl/max_pool_stream.sv | 140 ++++++++++++++
 tb/tb_max_pool_stream.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_stream.sv
// Streaming 2x2 max/average pooling of a raster-order frame using a half-width line buffer of pair results.
// The result is registered 1 cycle after its completing pixel; input stalls only while a held result is unaccepted.
module max_pool_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pool_mode_i,
  input  logic signed [DATA_WIDTH-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic signed [DATA_WIDTH-1:0] out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o
);
  localparam int SW       = DATA_WIDTH + 2;
  localparam int CW       = $clog2(IMG_WIDTH);
  localparam int RW       = $clog2(IMG_HEIGHT);
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [0:0] EVEN_ROW = 1'b0;
  localparam logic [0:0] ODD_ROW  = 1'b1;

  logic [CW-1:0]                col_q, col_d;
  logic [RW-1:0]                row_q, row_d;
  logic [0:0]                   state_q, state_d;
  logic                         mode_q, mode_d;
  logic signed [DATA_WIDTH-1:0] pair_q, pair_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;

  logic signed [SW-1:0]         lb_q [LB_DEPTH];
  logic                         lb_we;
  logic [LW-1:0]                lb_idx;
  logic signed [SW-1:0]         lb_rd;

  logic                         accept;
  logic                         col_end;
  logic                         row_end;
  logic signed [SW-1:0]         in_ext, pair_ext;
  logic signed [SW-1:0]         pair_max, pair_sum;
  logic signed [SW-1:0]         quad_max, quad_sum, quad_avg;
  logic signed [SW-1:0]         lb_wdata;
  logic [DATA_WIDTH-1:0]        quad_res;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;

  assign accept  = in_valid_i && in_ready_o;
  assign col_end = (col_q == CW'(IMG_WIDTH - 1));
  assign row_end = (row_q == RW'(IMG_HEIGHT - 1));
  assign lb_idx  = LW'(col_q >> 1);

  // Everything is widened by two bits so a four-pixel sum can never overflow.
  always_comb begin
    in_ext   = {{2{in_data_i[DATA_WIDTH-1]}}, in_data_i};
    pair_ext = {{2{pair_q[DATA_WIDTH-1]}}, pair_q};
    pair_max = (in_ext > pair_ext) ? in_ext : pair_ext;
    pair_sum = in_ext + pair_ext;
    lb_rd    = lb_q[lb_idx];
    quad_max = (pair_max > lb_rd) ? pair_max : lb_rd;
    quad_sum = pair_sum + lb_rd;
    quad_avg = quad_sum >>> 2;
    lb_wdata = mode_q ? pair_sum : pair_max;
    quad_res = mode_q ? quad_avg[DATA_WIDTH-1:0] : quad_max[DATA_WIDTH-1:0];
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    state_d     = state_q;
    mode_d      = mode_q;
    pair_d      = pair_q;
    lb_we       = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready_i;
    out_last_d  = out_last_q && out_valid_d;

    if (accept) begin
      if (col_end) begin
        col_d   = '0;
        row_d   = row_end ? '0 : row_q + RW'(1);
        state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end else begin
        col_d = col_q + CW'(1);
      end

      if (row_q == '0 && col_q == '0) begin
        mode_d = pool_mode_i;
      end

      if (!col_q[0]) begin
        pair_d = in_data_i;
      end else if (state_q == EVEN_ROW) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = quad_res;
        out_last_d  = row_end && col_end;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      state_q     <= EVEN_ROW;
      mode_q      <= 1'b0;
      pair_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      pair_q      <= pair_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer is never reset: an even row always fills an entry before the odd row reads it.
  always_ff @(posedge clk_i) begin
    if (lb_we) begin
      lb_q[lb_idx] <= lb_wdata;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: directed cases plus randomized frames checked against a pixel-grid model.
module tb_max_pool_stream;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mode_a, iv_a, ir_a, ov_a, ordy_a, last_a;
  logic [DW-1:0] din_a, dout_a;
  logic          mode_b, iv_b, ir_b, ov_b, ordy_b, last_b;
  logic [DW-1:0] din_b, dout_b;

  max_pool_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
    .clk_i(clk), .rst_i(rst), .pool_mode_i(mode_a), .in_data_i(din_a),
    .in_valid_i(iv_a), .in_ready_o(ir_a), .out_data_o(dout_a),
    .out_valid_o(ov_a), .out_ready_i(ordy_a), .out_last_o(last_a));

  max_pool_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_b (
    .clk_i(clk), .rst_i(rst), .pool_mode_i(mode_b), .in_data_i(din_b),
    .in_valid_i(iv_b), .in_ready_o(ir_b), .out_data_o(dout_b),
    .out_valid_o(ov_b), .out_ready_i(ordy_b), .out_last_o(last_b));

  int checks = 0;
  int errors = 0;
  int pix[16];
  int got_d_a[$], exp_d_a[$], got_d_b[$], exp_d_b[$];
  bit got_l_a[$], exp_l_a[$], got_l_b[$], exp_l_b[$];

  always @(negedge clk) begin
    if (!rst && ov_a && ordy_a) begin
      got_d_a.push_back(int'($signed(dout_a)));
      got_l_a.push_back(last_a);
    end
    if (!rst && ov_b && ordy_b) begin
      got_d_b.push_back(int'($signed(dout_b)));
      got_l_b.push_back(last_b);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int sel, input int d, input bit l);
    if (sel == 0) begin exp_d_a.push_back(d); exp_l_a.push_back(l); end
    else begin exp_d_b.push_back(d); exp_l_b.push_back(l); end
  endtask

  // Reference: pool each 2x2 block of the pixel grid directly.
  task automatic model(input int sel, input int w, input int h, input logic m);
    int a, b, c, d, s, v;
    for (int r = 0; r < h; r += 2) begin
      for (int k = 0; k < w; k += 2) begin
        a = pix[r*w + k];
        b = pix[r*w + k + 1];
        c = pix[(r+1)*w + k];
        d = pix[(r+1)*w + k + 1];
        if (m) begin
          s = a + b + c + d;
          v = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end else begin
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
        end
        expect_out(sel, v, (r == h - 2) && (k == w - 2));
      end
    end
  endtask

  task automatic push(input int sel, input int d, input logic m, input bit rnd);
    int n;
    n = 0;
    if (sel == 0) begin din_a = DW'(d); mode_a = m; iv_a = 1'b1; end
    else begin din_b = DW'(d); mode_b = m; iv_b = 1'b1; end
    forever begin
      if (rnd) begin
        if (sel == 0) ordy_a = ($urandom_range(0, 3) != 0);
        else ordy_b = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (((sel == 0) ? ir_a : ir_b) || n >= 64) break;
      n++;
      @(posedge clk); #1;
    end
    if (n >= 64) check("push_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int sel, input int w, input int h, input logic m0,
                            input bit toggle, input bit rnd);
    logic m;
    for (int i = 0; i < w*h; i++) begin
      m = (i == 0 || !toggle) ? m0 : ($urandom_range(0, 1) == 1);
      push(sel, pix[i], m, rnd);
    end
  endtask

  task automatic drain();
    iv_a = 1'b0; iv_b = 1'b0; ordy_a = 1'b1; ordy_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare(input int sel, input string tag);
    int gd[$], ed[$];
    bit gl[$], el[$];
    int n;
    if (sel == 0) begin
      gd = got_d_a; gl = got_l_a; ed = exp_d_a; el = exp_l_a;
      got_d_a.delete(); got_l_a.delete(); exp_d_a.delete(); exp_l_a.delete();
    end else begin
      gd = got_d_b; gl = got_l_b; ed = exp_d_b; el = exp_l_b;
      got_d_b.delete(); got_l_b.delete(); exp_d_b.delete(); exp_l_b.delete();
    end
    check({tag, "_count"}, gd.size(), ed.size());
    n = (gd.size() < ed.size()) ? gd.size() : ed.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), gd[i], ed[i]);
      check($sformatf("%s_last[%0d]", tag, i), int'(gl[i]), int'(el[i]));
    end
  endtask

  task automatic rand_pix(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0:       pix[i] = -128;
        1:       pix[i] = 127;
        default: pix[i] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    mode_a = 1'b0; iv_a = 1'b0; din_a = '0; ordy_a = 1'b0;
    mode_b = 1'b0; iv_b = 1'b0; din_b = '0; ordy_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(ov_a), 0);
    check("rst_out_data", int'(dout_a), 0);
    check("rst_out_last", int'(last_a), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", int'(ir_a), 1);

    // 4x4 ramp, max then average.
    for (int i = 0; i < 16; i++) pix[i] = i;
    ordy_a = 1'b1;
    send_frame(0, 4, 4, 1'b0, 1'b0, 1'b0);
    expect_out(0, 5, 0); expect_out(0, 7, 0); expect_out(0, 13, 0); expect_out(0, 15, 1);
    drain();
    compare(0, "ramp_max");
    send_frame(0, 4, 4, 1'b1, 1'b0, 1'b0);
    expect_out(0, 2, 0); expect_out(0, 4, 0); expect_out(0, 10, 0); expect_out(0, 12, 1);
    drain();
    compare(0, "ramp_avg");

    // Downstream stall while the first result is held.
    for (int i = 0; i < 6; i++) push(0, pix[i], 1'b0, 1'b0);
    ordy_a = 1'b0;
    din_a = DW'(6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(ir_a), 0);
      check("stall_out_valid", int'(ov_a), 1);
      check("stall_out_data", int'($signed(dout_a)), 5);
      check("stall_out_last", int'(last_a), 0);
    end
    @(posedge clk); #1;
    ordy_a = 1'b1;
    for (int i = 6; i < 16; i++) push(0, pix[i], 1'b0, 1'b0);
    expect_out(0, 5, 0); expect_out(0, 7, 0); expect_out(0, 13, 0); expect_out(0, 15, 1);
    drain();
    compare(0, "stall");

    // Reset mid-frame with a result pending.
    for (int i = 0; i < 6; i++) push(0, pix[i], 1'b1, 1'b0);
    ordy_a = 1'b0; iv_a = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", int'(ov_a), 0);
    got_d_a.delete(); got_l_a.delete();
    ordy_a = 1'b1;
    send_frame(0, 4, 4, 1'b0, 1'b0, 1'b0);
    expect_out(0, 5, 0); expect_out(0, 7, 0); expect_out(0, 13, 0); expect_out(0, 15, 1);
    drain();
    compare(0, "midrst");

    // Mode toggled on every pixel after the first.
    for (int f = 0; f < 4; f++) begin
      rand_pix(16);
      model(0, 4, 4, f[0]);
      send_frame(0, 4, 4, f[0], 1'b1, 1'b0);
    end
    drain();
    compare(0, "toggle");

    // Random back-to-back frames under random backpressure.
    for (int f = 0; f < 8; f++) begin
      logic m;
      m = ($urandom_range(0, 1) == 1);
      rand_pix(16);
      model(0, 4, 4, m);
      send_frame(0, 4, 4, m, 1'b0, 1'b1);
    end
    drain();
    compare(0, "random");

    // 2x2 negative corner case, then random 2x2 frames.
    pix[0] = -1; pix[1] = -2; pix[2] = -3; pix[3] = -4;
    ordy_b = 1'b1;
    send_frame(1, 2, 2, 1'b0, 1'b0, 1'b0);
    send_frame(1, 2, 2, 1'b1, 1'b0, 1'b0);
    expect_out(1, -1, 1); expect_out(1, -3, 1);
    drain();
    compare(1, "neg2x2");
    for (int f = 0; f < 6; f++) begin
      logic m;
      m = ($urandom_range(0, 1) == 1);
      rand_pix(4);
      model(1, 2, 2, m);
      send_frame(1, 2, 2, m, 1'b1, 1'b1);
    end
    drain();
    compare(1, "rand2x2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
